data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder that serves the core's load/store requests. Sits between the core's Mem stage and the on-chip data SRAM and owns the storage array. It accepts one request at a time over a valid/ready channel, inserts a configurable number of wait states, and performs byte-lane write masking and read alignment. It returns one response per request over a second valid/ready channel and flags misaligned or out-of-range accesses.

## Interface
- `DepthWords`, 4096: number of 64-bit storage words (power of two).
- `BaseAddr`, 64'h8000_0000: byte address of word 0.
- `WaitCycles`, 0: extra wait states per access (0..15).

- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  reset. Asynchronous and active-low.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  request accepted this cycle when high together with `ReqValid`.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `ReqAddr`  in  64  byte address.
- `ReqSize`  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = double.
- `ReqWdata`  in  64  store data, right-aligned (LSB at bit 0).
- `RespValid`  out  1  response present.
- `RespReady`  in  1  core consumes the response.
- `RespRdata`  out  64  load data, right-aligned and zero-extended to 64 bits. It is 0 for stores and for errors.
- `RespErr`  out  1  misaligned or out-of-range access.

## Operation
- FSM has three states.
  - IDLE: `ReqReady`=1.
  - BUSY: the counter runs.
  - RESP: `RespValid`=1.
- Accept (IDLE, `ReqValid`):
  - latch write, addr, size and wdata;
  - counter ← `WaitCycles`;
  - go to BUSY.
- BUSY with counter ≠ 0: decrement.
- BUSY with counter = 0: execute the access at this edge, register the response, go to RESP.
- Offset is `ReqAddr − BaseAddr`. Word index is offset[3+log2(DepthWords)−1:3]. Lane is offset[2:0].
- Misaligned: lane is not a multiple of the size in bytes.
- Out-of-range: offset ≥ `DepthWords`×8, or `ReqAddr` < `BaseAddr`.
- On either error: `RespErr`=1, `RespRdata`=0, no array write.
- Store:
  - byte-enable = ((1<<bytes)−1) << lane;
  - write data = `ReqWdata` << (lane×8);
  - only enabled bytes change.
- Load:
  - `RespRdata` = (word >> lane×8) masked to the size;
  - the core performs sign extension.
- RESP holds all response outputs stable until `RespReady`.
- RESP with `RespReady`:
  - `ReqReady`=1 in the same cycle;
  - if `ReqValid` is also high, the new request is accepted at that edge and the FSM goes straight to BUSY;
  - otherwise the FSM goes to IDLE.
- Storage is not reset. Contents persist across `Rst`.

## Timing
- Reset values: state IDLE, `RespValid`=0, `RespRdata`=0, `RespErr`=0, counter 0.
- `ReqReady` is 0 while `Rst` is asserted and 1 from the first cycle after deassertion.
- Latency: accept at edge k, then `RespValid` is high after edge k+1+`WaitCycles`.
- Peak throughput: one request per `WaitCycles`+2 cycles.
- A store is visible to a load accepted at any later edge. No forwarding is needed because only one access is in flight.
- Reset mid-operation: outputs clear immediately. A latched but unexecuted store is discarded. A store already executed is kept.
- `ReqReady` is combinational from state and `RespReady` only. It has no dependence on `ReqValid`.

## Structure
- Shared package `dmem_pkg`:
  - size encodings (`SizeB`, `SizeH`, `SizeW`, `SizeD`);
  - FSM state enum;
  - the `bytes(size)` function.
- Sub-module `dmem_lane_align` is combinational. It takes size, lane, wdata and the stored word. It produces byte-enable, the shifted write word, the aligned read data and the misalign flag.
- Top level holds the FSM, counter, request latch, response registers and the array.

## Test plan
- Store double 64'h1122334455667788 at 0x8000_0010, then load double at the same address → `RespRdata`=64'h1122334455667788, `RespErr`=0.
- Store byte 8'hAB at 0x8000_0013, then load double at 0x8000_0010 → only byte 3 changes: 64'h11223344AB667788. Then load half at 0x8000_0012 → 64'h0000_0000_0000_AB66.
- Load word at 0x8000_0006 → `RespErr`=1, `RespRdata`=0. Repeat as a store and confirm the array is unchanged. Load at 0x7FFF_FFF8 and at `BaseAddr`+`DepthWords`×8 → `RespErr`=1.
- `WaitCycles`=3: accept at edge k → `RespValid` rises after edge k+4. Hold `RespReady`=0 for 5 cycles → outputs stable. Assert `RespReady` together with a new `ReqValid` → second request accepted at the same edge.
- Assert `Rst` during BUSY of a store → `RespValid` drops immediately and a later load shows the old data. A store completed before reset is still readable after reset.
- Random back-to-back loads and stores against a byte-array model with random `RespReady` stalls → every response matches the model, and the response count equals the request count.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// Access size codes, FSM states, size-to-bytes helper.
package dmem_pkg;

  localparam logic [1:0] SizeB = 2'b00;
  localparam logic [1:0] SizeH = 2'b01;
  localparam logic [1:0] SizeW = 2'b10;
  localparam logic [1:0] SizeD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  function automatic logic [3:0] bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between right-aligned core data
// and the 64-bit storage word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  lane,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  byteEn,
  output logic [63:0] wword,
  output logic [63:0] rdata,
  output logic        misalign
);

  logic [3:0]  nBytes;
  logic [7:0]  sizeMask;
  logic [63:0] dataMask;

  // Lane enables, shifted store word, masked load word.
  always_comb begin
    nBytes   = bytes(size);
    sizeMask = 8'hFF;
    unique case (size)
      SizeB:   sizeMask = 8'h01;
      SizeH:   sizeMask = 8'h03;
      SizeW:   sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
    dataMask = '0;
    for (int i = 0; i < 8; i++) begin
      dataMask[i*8 +: 8] = {8{sizeMask[i]}};
    end
    byteEn   = sizeMask << lane;
    wword    = wdata << {lane, 3'b000};
    rdata    = (rword >> {lane, 3'b000}) & dataMask;
    misalign = (lane & 3'(nBytes - 4'd1)) != 3'd0;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder owning the data SRAM array.
// One access in flight, programmable wait states.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DepthWords = 4096,
  parameter logic [63:0] BaseAddr   = 64'h8000_0000,
  parameter int          WaitCycles = 0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [63:0] ReqAddr,
  input  logic [1:0]  ReqSize,
  input  logic [63:0] ReqWdata,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [63:0] RespRdata,
  output logic        RespErr
);

  localparam int          IdxW      = $clog2(DepthWords);
  localparam logic [63:0] SpanBytes = 64'(DepthWords) << 3;

  state_e      state;
  logic [3:0]  cnt;
  logic        lWrite;
  logic [63:0] lAddr;
  logic [1:0]  lSize;
  logic [63:0] lWdata;

  logic [63:0] mem [DepthWords];

  logic [63:0]     offset;
  logic [IdxW-1:0] wordIdx;
  logic [2:0]      lane;
  logic            outOfRange;
  logic            misalign;
  logic            err;
  logic            accept;
  logic            exec;
  logic [7:0]      byteEn;
  logic [63:0]     wword;
  logic [63:0]     rword;
  logic [63:0]     rdata;

  assign ReqReady = Rst &&
    (state == StIdle || (state == StResp && RespReady));
  assign accept = ReqValid && ReqReady;
  assign exec   = (state == StBusy) && (cnt == 4'd0);

  assign offset     = lAddr - BaseAddr;
  assign wordIdx    = offset[3 +: IdxW];
  assign lane       = offset[2:0];
  assign outOfRange = (lAddr < BaseAddr) || (offset >= SpanBytes);
  assign err        = outOfRange || misalign;
  assign rword      = mem[wordIdx];

  dmem_lane_align uAlign (
    .size    (lSize),
    .lane    (lane),
    .wdata   (lWdata),
    .rword   (rword),
    .byteEn  (byteEn),
    .wword   (wword),
    .rdata   (rdata),
    .misalign(misalign)
  );

  // Capture the request fields on every handshake.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lWrite <= 1'b0;
      lAddr  <= '0;
      lSize  <= SizeB;
      lWdata <= '0;
    end else if (accept) begin
      lWrite <= ReqWrite;
      lAddr  <= ReqAddr;
      lSize  <= ReqSize;
      lWdata <= ReqWdata;
    end
  end

  // Sequencer: wait-state countdown and registered response.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= StIdle;
      cnt       <= 4'd0;
      RespValid <= 1'b0;
      RespRdata <= '0;
      RespErr   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            cnt   <= 4'(WaitCycles);
            state <= StBusy;
          end
        end
        StBusy: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= StResp;
            RespValid <= 1'b1;
            RespErr   <= err;
            RespRdata <= (err || lWrite) ? '0 : rdata;
          end
        end
        StResp: begin
          if (RespReady) begin
            RespValid <= 1'b0;
            if (ReqValid) begin
              cnt   <= 4'(WaitCycles);
              state <= StBusy;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Storage write; contents survive reset by design.
  always_ff @(posedge Clk) begin
    if (exec && lWrite && !err) begin
      for (int i = 0; i < 8; i++) begin
        if (byteEn[i]) begin
          mem[wordIdx][i*8 +: 8] <= wword[i*8 +: 8];
        end
      end
    end
  end

endmodule
